uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rx_fifo.sv | 51 +++++
 rtl/uart_rx_ctrl.sv | 149 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive-controller state encoding and default sizing.
package uart_pkg;

  localparam int unsigned BYTESIZES_DEF  = 8;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    ACTIVE,
    DRAIN
  } rx_ctrl_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Capture buffer for the receive controller: first-word fall-through FIFO with
// wrap-bit pointers, so full and empty are told apart by the pointer MSB.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned BYTESIZES  = BYTESIZES_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                 clock_out,
  input  logic                 nreset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [BYTESIZES-1:0] din,
  output logic [BYTESIZES-1:0] dout,
  output logic                 full,
  output logic                 empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [BYTESIZES-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]          r_wr_ptr;
  logic [AW:0]          r_rd_ptr;
  logic                 w_do_push;
  logic                 w_do_pop;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = pop && !empty;
  // A pop frees the head slot this edge, so a full FIFO can still take a push.
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clock_out or negedge nreset) begin
    if (!nreset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock_out) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

  // Forced to zero when empty so stale storage never shows after reset.
  assign dout = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive burst controller: arms the receiver, captures completed frames
// into a FIFO, and closes a burst on disable, byte count or idle timeout.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned BYTESIZES      = BYTESIZES_DEF,
  parameter int unsigned FIFO_DEPTH     = FIFO_DEPTH_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clock_out,
  input  logic                 nreset,
  input  logic                 enable_in,
  input  logic [7:0]           byte_count_in,
  input  logic                 clear_in,
  input  logic                 rx_done_in,
  input  logic [BYTESIZES-1:0] rx_data_in,
  output logic                 rx_valid_out,
  output logic                 m_valid_out,
  input  logic                 m_ready_in,
  output logic [BYTESIZES-1:0] m_data_out,
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 overrun_out,
  output logic                 timeout_out
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT_CYCLES - 1);

  rx_ctrl_state_t r_state;
  rx_ctrl_state_t w_state_next;

  logic          r_rx_done_q;
  logic [7:0]    r_count;
  logic [7:0]    r_target;
  logic [TW-1:0] r_timer;
  logic          r_overrun;
  logic          r_timeout;

  logic          w_capture;
  logic          w_accept;
  logic [7:0]    w_count_next;
  logic          w_count_hit;
  logic          w_timer_hit;
  logic          w_arm;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_set_overrun;
  logic          w_set_timeout;

  assign w_capture     = rx_done_in && !r_rx_done_q;
  assign w_accept      = w_capture && (r_state != IDLE);
  assign w_count_next  = (w_accept && (r_count != 8'hFF)) ? r_count + 8'd1 : r_count;
  // Compared against the post-capture count so the Nth byte closes the burst.
  assign w_count_hit   = (r_target != 8'd0) && (w_count_next == r_target);
  assign w_timer_hit   = !w_capture && (r_timer == TimerLast);
  assign w_arm         = (r_state == IDLE) && enable_in;
  assign w_pop         = m_valid_out && m_ready_in;
  assign w_push        = w_accept && (!w_full || w_pop);
  assign w_set_overrun = w_accept && w_full && !w_pop;
  assign w_set_timeout = (r_state == ACTIVE) && enable_in && !w_count_hit && w_timer_hit;

  always_ff @(posedge clock_out or negedge nreset) begin
    if (!nreset) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (enable_in) w_state_next = ARMED;
      end
      ARMED: begin
        if (!enable_in || (w_capture && w_count_hit)) w_state_next = DRAIN;
        else if (w_capture)                           w_state_next = ACTIVE;
      end
      ACTIVE: begin
        if (!enable_in || w_count_hit || w_timer_hit) w_state_next = DRAIN;
      end
      DRAIN: begin
        // A frame already in flight when the burst closed still lands here.
        if (w_empty && !w_capture) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    rx_valid_out = 1'b0;
    done_out     = 1'b0;
    unique case (r_state)
      ARMED, ACTIVE: rx_valid_out = 1'b1;
      DRAIN:         done_out     = w_empty && !w_capture;
      default:       ;
    endcase
  end

  always_ff @(posedge clock_out or negedge nreset) begin
    if (!nreset) begin
      r_rx_done_q <= 1'b1;
      r_count     <= 8'd0;
      r_target    <= 8'd0;
      r_timer     <= '0;
      r_overrun   <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_rx_done_q <= rx_done_in;

      if (w_arm) begin
        r_count  <= 8'd0;
        r_target <= byte_count_in;
      end else begin
        r_count  <= w_count_next;
      end

      if ((r_state == ACTIVE) && !w_capture) r_timer <= r_timer + TW'(1);
      else                                   r_timer <= '0;

      if (w_set_overrun) r_overrun <= 1'b1;
      else if (clear_in) r_overrun <= 1'b0;

      if (w_set_timeout)          r_timeout <= 1'b1;
      else if (clear_in || w_arm) r_timeout <= 1'b0;
    end
  end

  assign busy_out    = (r_state != IDLE);
  assign m_valid_out = !w_empty;
  assign overrun_out = r_overrun;
  assign timeout_out = r_timeout;

  uart_rx_fifo #(
    .BYTESIZES (BYTESIZES),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock_out(clock_out),
    .nreset   (nreset),
    .push     (w_push),
    .pop      (w_pop),
    .din      (rx_data_in),
    .dout     (m_data_out),
    .full     (w_full),
    .empty    (w_empty)
  );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed vector table, corner-case sequences and a
// randomized run checked cycle by cycle against a queue-based burst model.
module tb_uart_rx_ctrl;

  localparam int unsigned BW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 16;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic          clock_out = 1'b0;
  logic          nreset = 1'b1;
  logic          enable_in = 1'b0;
  logic [7:0]    byte_count_in = 8'd0;
  logic          clear_in = 1'b0;
  logic          rx_done_in = 1'b0;
  logic [BW-1:0] rx_data_in = '0;
  logic          m_ready_in = 1'b0;
  logic          rx_valid_out, m_valid_out, busy_out, done_out, overrun_out, timeout_out;
  logic [BW-1:0] m_data_out;

  uart_rx_ctrl #(
    .BYTESIZES     (BW),
    .FIFO_DEPTH    (DEPTH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock_out    (clock_out),
    .nreset       (nreset),
    .enable_in    (enable_in),
    .byte_count_in(byte_count_in),
    .clear_in     (clear_in),
    .rx_done_in   (rx_done_in),
    .rx_data_in   (rx_data_in),
    .rx_valid_out (rx_valid_out),
    .m_valid_out  (m_valid_out),
    .m_ready_in   (m_ready_in),
    .m_data_out   (m_data_out),
    .busy_out     (busy_out),
    .done_out     (done_out),
    .overrun_out  (overrun_out),
    .timeout_out  (timeout_out)
  );

  always #5 clock_out = ~clock_out;

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
  endtask

  // Reference model: burst phase, byte queue, counts and sticky flags.
  localparam int P_IDLE = 0, P_ARMED = 1, P_ACTIVE = 2, P_DRAIN = 3;
  int            md_phase, md_cnt, md_target, md_quiet;
  bit            md_prev, md_ovr, md_to;
  logic [BW-1:0] md_q[$];
  logic [BW-1:0] popped[$];

  function automatic void md_reset();
    md_phase = P_IDLE; md_cnt = 0; md_target = 0; md_quiet = 0;
    md_prev = 1'b1; md_ovr = 1'b0; md_to = 1'b0;
    md_q.delete();
  endfunction

  function automatic logic [BW+5:0] md_expect();
    bit v   = (md_q.size() != 0);
    bit cap = rx_done_in && !md_prev;
    return {(md_phase == P_ARMED) || (md_phase == P_ACTIVE), v,
            v ? md_q[0] : {BW{1'b0}}, md_phase != P_IDLE,
            (md_phase == P_DRAIN) && !v && !cap, md_ovr, md_to};
  endfunction

  function automatic logic [BW+5:0] dut_obs();
    return {rx_valid_out, m_valid_out, m_valid_out ? m_data_out : {BW{1'b0}},
            busy_out, done_out, overrun_out, timeout_out};
  endfunction

  function automatic void md_step();
    bit cap       = rx_done_in && !md_prev;
    bit pop       = (md_q.size() != 0) && m_ready_in;
    bit was_full  = (md_q.size() == DEPTH);
    bit was_empty = (md_q.size() == 0);
    bit hit;
    if (clear_in) begin md_ovr = 1'b0; md_to = 1'b0; end
    if (pop) void'(md_q.pop_front());
    if (md_phase != P_IDLE && cap) begin
      if (md_cnt < 255) md_cnt++;
      if (!was_full || pop) md_q.push_back(rx_data_in);
      else md_ovr = 1'b1;
    end
    hit = (md_target != 0) && (md_cnt == md_target);
    case (md_phase)
      P_IDLE: if (enable_in) begin
        md_phase = P_ARMED; md_target = byte_count_in; md_cnt = 0; md_to = 1'b0;
      end
      P_ARMED: begin
        if (!enable_in) md_phase = P_DRAIN;
        else if (cap) begin md_phase = hit ? P_DRAIN : P_ACTIVE; md_quiet = 0; end
      end
      P_ACTIVE: begin
        if (!enable_in || hit) md_phase = P_DRAIN;
        else if (!cap && md_quiet == TMO - 1) begin md_phase = P_DRAIN; md_to = 1'b1; end
        if (cap) md_quiet = 0; else md_quiet++;
      end
      default: if (was_empty && !cap) md_phase = P_IDLE;
    endcase
    md_prev = rx_done_in;
  endfunction

  task automatic sample();
    chk("model", 32'(dut_obs()), 32'(md_expect()));
    if (m_valid_out && m_ready_in) popped.push_back(m_data_out);
  endtask

  task automatic advance();
    @(posedge clock_out);
    md_step();
    #1;
  endtask

  task automatic step();
    #1;
    sample();
    advance();
  endtask

  task automatic cap_byte(input logic [BW-1:0] d);
    rx_done_in = 1'b1; rx_data_in = d; step();
    rx_done_in = 1'b0; step();
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    #1;
    chk("reset_outputs", 32'({rx_valid_out, m_valid_out, m_data_out, busy_out, done_out,
                              overrun_out, timeout_out}), 32'd0);
    md_reset();
    popped.delete();
    enable_in = 1'b0; clear_in = 1'b0;
    @(negedge clock_out);
    nreset = 1'b1;
    advance();
  endtask

  typedef struct {
    logic en; logic rxd; logic [BW-1:0] data; logic rdy;
    logic e_rxv; logic e_mv; logic [BW-1:0] e_md; logic e_busy; logic e_done;
  } vec_t;
  vec_t tbl[9];

  int n, rate;
  int burst_len;

  initial begin
    // Count-of-3 burst with the stream always ready.
    tbl[0] = '{H, L, 8'h00, H,  L, L, 8'h00, L, L};
    tbl[1] = '{H, H, 8'h11, H,  H, L, 8'h00, H, L};
    tbl[2] = '{H, L, 8'h11, H,  H, H, 8'h11, H, L};
    tbl[3] = '{H, H, 8'h22, H,  H, L, 8'h00, H, L};
    tbl[4] = '{H, L, 8'h22, H,  H, H, 8'h22, H, L};
    tbl[5] = '{H, H, 8'h33, H,  H, L, 8'h00, H, L};
    tbl[6] = '{H, L, 8'h33, H,  L, H, 8'h33, H, L};
    tbl[7] = '{H, L, 8'h33, H,  L, L, 8'h00, H, H};
    tbl[8] = '{L, L, 8'h33, H,  L, L, 8'h00, L, L};

    #2;
    do_reset();
    byte_count_in = 8'd3;
    for (int i = 0; i < 9; i++) begin
      enable_in = tbl[i].en; rx_done_in = tbl[i].rxd;
      rx_data_in = tbl[i].data; m_ready_in = tbl[i].rdy;
      #1;
      chk($sformatf("vec%0d", i),
          32'({rx_valid_out, m_valid_out, tbl[i].e_mv ? m_data_out : 8'h00, busy_out, done_out}),
          32'({tbl[i].e_rxv, tbl[i].e_mv, tbl[i].e_md, tbl[i].e_busy, tbl[i].e_done}));
      sample();
      advance();
    end
    chk("count3_len", popped.size(), 3);
    for (int i = 0; i < 3; i++) chk($sformatf("count3_b%0d", i), popped[i], 32'h11 * (i + 1));

    // Overrun: six bytes into a four-deep FIFO with no reader.
    do_reset();
    byte_count_in = 8'd0; m_ready_in = 1'b0; enable_in = 1'b1; step();
    for (int i = 0; i < 6; i++) cap_byte(8'(8'hA0 + i));
    chk("overrun_set", overrun_out, 1);
    m_ready_in = 1'b1; enable_in = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("overrun_len", popped.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("overrun_b%0d", i), popped[i], 32'hA0 + i);
    chk("overrun_held", overrun_out, 1);
    clear_in = 1'b1; step(); clear_in = 1'b0;
    chk("overrun_clear", overrun_out, 0);

    // Timeout: one byte then silence; done waits for the reader.
    do_reset();
    byte_count_in = 8'd0; m_ready_in = 1'b0; enable_in = 1'b1; step();
    rx_done_in = 1'b1; rx_data_in = 8'h5C; step(); rx_done_in = 1'b0;
    n = 0;
    while (rx_valid_out && n < 100) begin step(); n++; end
    chk("timeout_cycles", n, TMO);
    chk("timeout_flag", timeout_out, 1);
    chk("timeout_no_done", {busy_out, done_out, m_valid_out}, 3'b101);
    m_ready_in = 1'b1; enable_in = 1'b0; step();
    chk("timeout_done", {busy_out, done_out}, 2'b11);
    step();
    chk("timeout_idle", {busy_out, done_out, timeout_out}, 3'b001);
    clear_in = 1'b1; step(); clear_in = 1'b0;
    chk("timeout_clear", timeout_out, 0);

    // Full FIFO with a pop on the same cycle as a capture.
    do_reset();
    byte_count_in = 8'd0; m_ready_in = 1'b0; enable_in = 1'b1; step();
    for (int i = 0; i < 4; i++) cap_byte(8'(8'hC0 + i));
    rx_done_in = 1'b1; rx_data_in = 8'hC4; m_ready_in = 1'b1; step();
    rx_done_in = 1'b0; enable_in = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("fullpop_ovr", overrun_out, 0);
    chk("fullpop_len", popped.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("fullpop_b%0d", i), popped[i], 32'hC0 + i);

    // Held rx_done gives one byte; enable dropped while armed.
    do_reset();
    byte_count_in = 8'd0; m_ready_in = 1'b0; enable_in = 1'b1; step();
    rx_done_in = 1'b1; rx_data_in = 8'h5A;
    for (int i = 0; i < 20; i++) step();
    rx_done_in = 1'b0; enable_in = 1'b0; m_ready_in = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("held_len", popped.size(), 1);
    chk("held_b0", popped[0], 8'h5A);
    enable_in = 1'b1; step();
    chk("armed_rxv", {rx_valid_out, busy_out}, 2'b11);
    enable_in = 1'b0; step();
    chk("armed_drop", {rx_valid_out, busy_out, done_out}, 3'b011);
    step();
    chk("armed_idle", {busy_out, done_out}, 2'b00);

    // Reset mid-burst with two bytes buffered and rx_done held high.
    do_reset();
    byte_count_in = 8'd0; m_ready_in = 1'b0; enable_in = 1'b1; step();
    cap_byte(8'hD0); cap_byte(8'hD1);
    chk("pre_reset_valid", {m_valid_out, rx_valid_out}, 2'b11);
    rx_done_in = 1'b1; rx_data_in = 8'hEE;
    do_reset();
    enable_in = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("post_reset_nocap", {m_valid_out, rx_valid_out}, 2'b01);
    rx_done_in = 1'b0; enable_in = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("post_reset_idle", {busy_out, m_valid_out}, 2'b00);

    // Randomized bursts against the model.
    do_reset();
    for (int b = 0; b < 40; b++) begin
      if (b % 13 == 7) do_reset();
      byte_count_in = 8'($urandom_range(0, 6));
      enable_in = 1'b1;
      rate = $urandom_range(2, 30);
      burst_len = $urandom_range(5, 60);
      for (int c = 0; c < burst_len; c++) begin
        if (!rx_done_in && $urandom_range(1, rate) == 1) begin
          rx_done_in = 1'b1; rx_data_in = BW'($urandom);
        end else if (rx_done_in && $urandom_range(0, 1) == 0) begin
          rx_done_in = 1'b0;
        end
        m_ready_in = ($urandom_range(0, 2) != 0);
        clear_in   = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 40) == 0) enable_in = 1'b0;
        step();
      end
      enable_in = 1'b0; rx_done_in = 1'b0; clear_in = 1'b0; m_ready_in = 1'b1;
      n = 0;
      while (busy_out && n < 50) begin step(); n++; end
      chk("settle_idle", busy_out, 0);
      popped.delete();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
